// File: rtl/stream_pack_pkg.sv
// Shared types and defaults for the stream word packer.
package stream_pack_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_PACK       = 4;

  function automatic int count_bits(input int pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/stream_pack_timer.sv
// Idle counter for the packer: expire_o fires on the TIMEOUT-th consecutive idle cycle.
module stream_pack_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Saturates one below TIMEOUT so expiry keeps asserting until something clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != TW'(TIMEOUT - 1))) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  assign expire_o = inc_i && (cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_word_packer.sv
// Packs PACK consecutive DATA_WIDTH words into one wide beat; partial beats on flush.
// Idle auto-flush is built only when STREAM_PACK_TIMEOUT_EN is defined.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid holds data stable until then.
module stream_word_packer
  import stream_pack_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PACK       = DEFAULT_PACK,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_flush,
  output logic [DATA_WIDTH*PACK-1:0]     out_data,
  output logic [count_bits(PACK)-1:0]    out_count,
  output logic                           out_valid,
  input  logic                           out_ready,
  output state_t                         dbg_state
);

  localparam int CW = count_bits(PACK);

  logic [PACK-1:0][DATA_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d, cnt_n, out_count_q, out_count_d;
  logic          out_valid_q, out_valid_d, flush_pend_q, flush_pend_d;
  state_t        state_q, state_d;
  logic          slot_free, accept, pend, load_out, timer_expire;

  assign in_ready  = reset && (state_q != FULL);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

  always_comb begin
    slot_free    = !out_valid_q || out_ready;
    accept       = in_valid && in_ready;
    pend         = flush_pend_q || in_flush || timer_expire;
    acc_d        = acc_q;
    cnt_n        = acc_cnt_q + {{(CW-1){1'b0}}, accept};
    for (int k = 0; k < PACK; k++) begin
      if (accept && (CW'(k) == acc_cnt_q)) acc_d[k] = in_data;
    end
    acc_cnt_d    = cnt_n;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q && !out_ready;
    load_out     = 1'b0;
    // A flush that finds nothing to emit is dropped rather than left pending.
    flush_pend_d = pend && (cnt_n != '0);

    if (cnt_n == CW'(PACK)) begin
      load_out = slot_free;
    end else if (pend && (cnt_n != '0) && slot_free) begin
      load_out = 1'b1;
    end

    // Unused lanes are already zero because acc is cleared on every emit.
    if (load_out) begin
      out_data_d   = acc_d;
      out_count_d  = cnt_n;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      acc_cnt_d    = '0;
      flush_pend_d = 1'b0;
    end

    if (acc_cnt_d == CW'(PACK))  state_d = FULL;
    else if (acc_cnt_d == '0)    state_d = EMPTY;
    else                         state_d = FILL;
  end

`ifdef STREAM_PACK_TIMEOUT_EN
  stream_pack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept || load_out),
    .inc_i    ((acc_cnt_q != '0) && !accept),
    .expire_o (timer_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timer_expire   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      state_q      <= EMPTY;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
    end
  end

endmodule
